// File: rtl/ram_loader_pkg.sv
// Shared widths and loader state encoding for the program-RAM loader.
// The default widths describe the 32 x 8 program RAM.
package ram_loader_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_WORD_SIZE  = 8;
  localparam int unsigned DEF_RAM_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } loader_state_t;

  function automatic logic state_busy(input loader_state_t s);
    return (s == LOAD) || (s == VERIFY);
  endfunction

endpackage

// File: rtl/ram_loader_checksum_acc.sv
// Clearable modulo-2^WORD_SIZE accumulator with enable.
// sum_next is the sum including the current data word, so callers can see a final total before it registers.
module checksum_acc #(
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [WORD_SIZE-1:0] data,
  output logic [WORD_SIZE-1:0] sum,
  output logic [WORD_SIZE-1:0] sum_next
);

  always_comb sum_next = sum + data;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Loads a valid/ready byte stream into consecutive RAM words from address 0,
// then reads the range back and compares the additive checksum of both passes.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
  parameter int unsigned DEPTH      = DEF_RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  in_valid,
  input  logic [WORD_SIZE-1:0]  in_data,
  output logic                  in_ready,
  output logic                  ram_read_en,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [WORD_SIZE-1:0]  ram_write_data,
  input  logic [WORD_SIZE-1:0]  ram_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WORD_SIZE-1:0]  checksum
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  loader_state_t         state;
  logic [ADDR_WIDTH:0]   counter;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  beat;
  logic                  last;
  logic                  start_ok;
  logic                  len_ok;
  logic [WORD_SIZE-1:0]  load_sum;
  logic [WORD_SIZE-1:0]  load_next;
  logic [WORD_SIZE-1:0]  verify_sum;
  logic [WORD_SIZE-1:0]  verify_next;

  always_comb begin
    beat     = (state == LOAD) && in_valid;
    last     = (counter == (len_q - ONE));
    start_ok = start && ((state == IDLE) || (state == DONE));
    len_ok   = (len != '0) && (len <= DEPTH_L);
  end

  // Address and write data are forced to 0 unless a RAM access is actually being made.
  always_comb begin
    in_ready       = (state == LOAD);
    busy           = state_busy(state);
    done           = (state == DONE);
    ram_write_en   = beat;
    ram_read_en    = (state == VERIFY);
    ram_address    = (beat || (state == VERIFY)) ? counter[ADDR_WIDTH-1:0] : '0;
    ram_write_data = beat ? in_data : '0;
  end

  checksum_acc #(.WORD_SIZE(WORD_SIZE)) u_load_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .en       (beat),
    .data     (in_data),
    .sum      (load_sum),
    .sum_next (load_next)
  );

  checksum_acc #(.WORD_SIZE(WORD_SIZE)) u_verify_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .en       (state == VERIFY),
    .data     (ram_read_data),
    .sum      (verify_sum),
    .sum_next (verify_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      len_q    <= '0;
      checksum <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q    <= len;
            counter  <= '0;
            checksum <= '0;
            error    <= !len_ok;
            state    <= len_ok ? LOAD : DONE;
          end
        end
        LOAD: begin
          if (beat) begin
            if (last) begin
              state    <= VERIFY;
              counter  <= '0;
              checksum <= load_next;
            end else begin
              counter <= counter + ONE;
            end
          end
        end
        VERIFY: begin
          // The last read word is still combinational, so compare against the unregistered total.
          if (last) begin
            state   <= DONE;
            counter <= '0;
            error   <= (verify_next != load_sum);
          end else begin
            counter <= counter + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_verify_sum;
  assign unused_verify_sum = ^verify_sum;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a behavioural 32 x 8 RAM plus a reference model
// built from the load/verify rules (expected write list, sums, timing).
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [5:0] len;
  logic [7:0] in_data;
  logic       in_ready, ram_read_en, ram_write_en, busy, done, error;
  logic [4:0] ram_address;
  logic [7:0] ram_write_data, ram_read_data, checksum;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_WIDTH(5), .WORD_SIZE(8), .DEPTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .len            (len),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .ram_read_en    (ram_read_en),
    .ram_write_en   (ram_write_en),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .checksum       (checksum)
  );

  // Behavioural RAM with an optional read corruption at one address
  logic [7:0] mem [0:31];
  logic       corrupt_en = 1'b0;
  logic [4:0] corrupt_addr = '0;
  always @(posedge clk) if (ram_write_en) mem[ram_address] <= ram_write_data;
  always_comb ram_read_data = (corrupt_en && ram_address == corrupt_addr) ? 8'h00 : mem[ram_address];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], rd_addr_q[$], rd_cyc_q[$];
  int both_en_cnt, oob_cnt, idle_drive_cnt;
  int exp_len;
  always @(negedge clk) begin
    if (ram_write_en && ram_read_en) both_en_cnt++;
    if ((ram_write_en || ram_read_en) && int'(ram_address) >= exp_len) oob_cnt++;
    if (!busy && (ram_address != 5'd0 || ram_write_data != 8'd0)) idle_drive_cnt++;
    if (ram_write_en) begin
      wr_addr_q.push_back(int'(ram_address));
      wr_data_q.push_back(int'(ram_write_data));
      wr_cyc_q.push_back(cyc);
    end
    if (ram_read_en) begin
      rd_addr_q.push_back(int'(ram_address));
      rd_cyc_q.push_back(cyc);
    end
  end

  logic [7:0] stim [0:31];
  int vpat[$];
  int start_cyc, done_cyc, stalls;

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
    both_en_cnt = 0; oob_cnt = 0; idle_drive_cnt = 0;
  endtask

  // Start a sequence and stream n bytes; gaps follow vpat if set, else random at gap_pct.
  // With noise set, start is toggled randomly while the loader is busy.
  task automatic run_load(input logic [5:0] l, input int n, input int gap_pct, input bit noise);
    int idx = 0;
    int step = 0;
    int budget = 400;
    clear_log();
    stalls = 0;
    exp_len = (l >= 1 && l <= 32) ? int'(l) : 0;
    @(posedge clk); #1;
    start = 1'b1; len = l;
    @(posedge clk); #1;
    start = 1'b0; start_cyc = cyc;
    while (idx < n && budget > 0) begin
      if (vpat.size() > 0) in_valid = (vpat[step % vpat.size()] != 0);
      else in_valid = ($urandom_range(99) >= gap_pct);
      in_data = stim[idx];
      if (noise) begin start = 1'($urandom_range(1)); len = 6'($urandom_range(63)); end
      if (!in_valid) stalls++;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      step++; budget--;
    end
    in_valid = 1'b0; in_data = 8'($urandom); start = 1'b0;
    done_cyc = -1;
    budget = 200;
    while (budget > 0) begin
      @(negedge clk);
      if (done) begin start = 1'b0; done_cyc = cyc - start_cyc; break; end
      @(posedge clk); #1;
      if (noise) begin start = 1'($urandom_range(1)); len = 6'($urandom_range(63)); end
      budget--;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, ram_read_en, ram_write_en, busy, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000",
               {in_ready, ram_read_en, ram_write_en, busy, done, error});
    end
    checks++;
    if (ram_address !== 5'd0 || ram_write_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_ram_bus: got addr=%0h data=%0h expected 0/0", ram_address, ram_write_data);
    end
    checks++;
    if (checksum !== 8'd0) begin
      failures++;
      $display("FAIL reset_checksum: got %0h expected 0", checksum);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b in_ready=%b expected 0/0/0", busy, done, in_ready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
    vpat = '{1};
    run_load(6'd4, 4, 0, 1'b0);
    checks++;
    if (done_cyc !== 8) begin failures++; $display("FAIL basic_done_latency: got %0d expected 8", done_cyc); end
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL basic_error: got %b expected 0", error); end
    checks++;
    if (checksum !== 8'h0A) begin failures++; $display("FAIL basic_checksum: got %0h expected 0a", checksum); end
    checks++;
    if (wr_addr_q.size() != 4 || rd_addr_q.size() != 4) begin
      failures++;
      $display("FAIL basic_counts: got wr=%0d rd=%0d expected 4/4", wr_addr_q.size(), rd_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[i] != i || wr_data_q[i] != int'(stim[i]) || wr_cyc_q[i] - start_cyc != i) begin
          failures++;
          $display("FAIL basic_write%0d: got a=%0d d=%0h t=%0d expected a=%0d d=%0h t=%0d",
                   i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - start_cyc, i, stim[i], i);
        end
        checks++;
        if (rd_addr_q[i] != i || rd_cyc_q[i] - start_cyc != 4 + i) begin
          failures++;
          $display("FAIL basic_read%0d: got a=%0d t=%0d expected a=%0d t=%0d",
                   i, rd_addr_q[i], rd_cyc_q[i] - start_cyc, i, 4 + i);
        end
        checks++;
        if (mem[i] !== stim[i]) begin failures++; $display("FAIL basic_mem%0d: got %0h expected %0h", i, mem[i], stim[i]); end
      end
    end
    checks++;
    if (both_en_cnt != 0 || idle_drive_cnt != 0) begin
      failures++;
      $display("FAIL basic_bus_rules: got both_en=%0d idle_drive=%0d expected 0/0", both_en_cnt, idle_drive_cnt);
    end
  endtask

  task automatic test_backpressure();
    int exp_t[3] = '{0, 3, 5};
    int sum = 0;
    for (int i = 0; i < 3; i++) begin stim[i] = 8'($urandom); sum += int'(stim[i]); end
    vpat = '{1, 0, 0, 1, 0, 1};
    run_load(6'd3, 3, 0, 1'b0);
    checks++;
    if (done_cyc !== 9 || error !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: got t=%0d error=%b expected t=9 error=0", done_cyc, error);
    end
    checks++;
    if (checksum !== 8'(sum)) begin failures++; $display("FAIL bp_checksum: got %0h expected %0h", checksum, 8'(sum)); end
    checks++;
    if (wr_addr_q.size() != 3) begin
      failures++;
      $display("FAIL bp_write_count: got %0d expected 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_q[i] != i || wr_data_q[i] != int'(stim[i]) || wr_cyc_q[i] - start_cyc != exp_t[i]) begin
          failures++;
          $display("FAIL bp_write%0d: got a=%0d d=%0h t=%0d expected a=%0d d=%0h t=%0d",
                   i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - start_cyc, i, stim[i], exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 32; i++) stim[i] = 8'hFF;
    vpat = '{1};
    run_load(6'd32, 32, 0, 1'b0);
    checks++;
    if (checksum !== 8'hE0 || error !== 1'b0) begin
      failures++;
      $display("FAIL full_result: got checksum=%0h error=%b expected e0/0", checksum, error);
    end
    checks++;
    if (done_cyc !== 64) begin failures++; $display("FAIL full_latency: got %0d expected 64", done_cyc); end
    checks++;
    if (wr_addr_q.size() != 32 || rd_addr_q.size() != 32 || oob_cnt != 0) begin
      failures++;
      $display("FAIL full_counts: got wr=%0d rd=%0d oob=%0d expected 32/32/0", wr_addr_q.size(), rd_addr_q.size(), oob_cnt);
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (wr_addr_q[i] != i || rd_addr_q[i] != i) begin
          failures++;
          $display("FAIL full_addr%0d: got wr=%0d rd=%0d expected %0d", i, wr_addr_q[i], rd_addr_q[i], i);
        end
      end
    end
  endtask

  task automatic test_illegal_len();
    logic [5:0] bad [2] = '{6'd0, 6'd33};
    vpat = '{1};
    for (int k = 0; k < 2; k++) begin
      run_load(bad[k], 0, 0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (done_cyc !== 0 || done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal_len%0d: got t=%0d done=%b error=%b busy=%b expected 0/1/1/0",
                 bad[k], done_cyc, done, error, busy);
      end
      checks++;
      if (wr_addr_q.size() != 0 || rd_addr_q.size() != 0 || checksum !== 8'd0) begin
        failures++;
        $display("FAIL illegal_access%0d: got wr=%0d rd=%0d checksum=%0h expected 0/0/0",
                 bad[k], wr_addr_q.size(), rd_addr_q.size(), checksum);
      end
    end
  endtask

  task automatic test_corruption();
    int lsum, vsum;
    logic exp_err;
    stim[0] = 8'($urandom);
    stim[1] = 8'($urandom_range(255, 1));
    lsum = int'(stim[0]) + int'(stim[1]);
    vsum = int'(stim[0]);
    exp_err = (8'(vsum) != 8'(lsum));
    corrupt_en = 1'b1; corrupt_addr = 5'd1;
    vpat = '{1};
    run_load(6'd2, 2, 0, 1'b0);
    corrupt_en = 1'b0;
    checks++;
    if (done !== 1'b1 || error !== exp_err) begin
      failures++;
      $display("FAIL corrupt_error: got done=%b error=%b expected 1/%b", done, error, exp_err);
    end
    checks++;
    if (checksum !== 8'(lsum) || mem[1] !== stim[1]) begin
      failures++;
      $display("FAIL corrupt_load: got checksum=%0h mem1=%0h expected %0h/%0h", checksum, mem[1], 8'(lsum), stim[1]);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    for (int i = 0; i < 5; i++) stim[i] = 8'($urandom);
    clear_log();
    exp_len = 5;
    @(posedge clk); #1 start = 1'b1; len = 6'd5;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1;
    for (int s = 0; s < 10 && beats < 2; s++) begin
      in_data = stim[beats];
      @(negedge clk);
      if (in_ready) beats++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 in_valid = 1'b1; in_data = stim[2];
    @(negedge clk);
    checks++;
    if ({in_ready, ram_read_en, ram_write_en, busy, done, error} !== 6'b0 ||
        ram_address !== 5'd0 || ram_write_data !== 8'd0 || checksum !== 8'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got flags=%b addr=%0h data=%0h checksum=%0h expected all 0",
               {in_ready, ram_read_en, ram_write_en, busy, done, error}, ram_address, ram_write_data, checksum);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_write_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle: got we=%b in_ready=%b busy=%b expected 0/0/0", ram_write_en, in_ready, busy);
    end
    checks++;
    if (wr_addr_q.size() != 2 || mem[0] !== stim[0] || mem[1] !== stim[1]) begin
      failures++;
      $display("FAIL midreset_kept: got writes=%0d mem0=%0h mem1=%0h expected 2/%0h/%0h",
               wr_addr_q.size(), mem[0], mem[1], stim[0], stim[1]);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    stim[0] = 8'($urandom);
    vpat = '{1};
    run_load(6'd1, 1, 0, 1'b0);
    checks++;
    if (done_cyc !== 2 || error !== 1'b0 || checksum !== stim[0] || mem[0] !== stim[0]) begin
      failures++;
      $display("FAIL midreset_recover: got t=%0d error=%b checksum=%0h mem0=%0h expected 2/0/%0h/%0h",
               done_cyc, error, checksum, mem[0], stim[0], stim[0]);
    end
  endtask

  task automatic test_random();
    vpat.delete();
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(32, 1);
      int sum = 0;
      int bad = 0;
      for (int i = 0; i < n; i++) begin stim[i] = 8'($urandom); sum += int'(stim[i]); end
      run_load(6'(n), n, 30, 1'b1);
      checks++;
      if (done_cyc !== 2 * n + stalls || error !== 1'b0 || checksum !== 8'(sum)) begin
        failures++;
        $display("FAIL rand%0d_result: got t=%0d error=%b checksum=%0h expected t=%0d error=0 checksum=%0h",
                 r, done_cyc, error, checksum, 2 * n + stalls, 8'(sum));
      end
      checks++;
      if (wr_addr_q.size() != n || rd_addr_q.size() != n || both_en_cnt != 0 || oob_cnt != 0) begin
        failures++;
        $display("FAIL rand%0d_counts: got wr=%0d rd=%0d both=%0d oob=%0d expected %0d/%0d/0/0",
                 r, wr_addr_q.size(), rd_addr_q.size(), both_en_cnt, oob_cnt, n, n);
      end else begin
        for (int i = 0; i < n; i++)
          if (wr_addr_q[i] != i || wr_data_q[i] != int'(stim[i]) || rd_addr_q[i] != i || mem[i] !== stim[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rand%0d_data: got %0d bad words expected 0", r, bad); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    exp_len = 0;
    clear_log();
    test_reset();
    test_basic();
    test_backpressure();
    test_full_wrap();
    test_illegal_len();
    test_corruption();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
